// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle chunked adder.
package adder_pkg;

  // Controller states: waiting for operands, adding chunks, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Integer ceiling division, used to size the number of chunks.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             C_in,
  output logic [CHUNK-1:0] S,
  output logic             C_out
);

  logic [CHUNK:0] carry;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    carry    = '0;
    S        = '0;
    carry[0] = C_in;
    for (int i = 0; i < CHUNK; i++) begin
      S[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
    end
    C_out = carry[CHUNK];
  end

endmodule

// File: rtl/multicycle_adder.sv
// Sequential adder/subtractor: processes CHUNK bits per clock with the
// inter-chunk carry held in a register, behind valid/ready handshakes.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             Sub,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V,
  output logic             Out_valid,
  input  logic             Out_ready
);

  localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   opA_q;
  logic [PW-1:0]   opB_q;
  logic [PW-1:0]   res_q;
  logic            c_q;
  logic [IDXW-1:0] idx_q;

  logic             accept;
  logic             lastChunk;
  logic [WIDTH-1:0] bIn;
  logic [CHUNK-1:0] chunkA, chunkB, chunkSum;
  logic             chunkCarry;

  assign accept    = In_valid && (state_q == IDLE);
  assign lastChunk = (idx_q == LAST_IDX);
  assign bIn       = Sub ? ~B : B;

  assign chunkA = opA_q[idx_q*CHUNK +: CHUNK];
  assign chunkB = opB_q[idx_q*CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .A     (chunkA),
    .B     (chunkB),
    .C_in  (c_q),
    .S     (chunkSum),
    .C_out (chunkCarry)
  );

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic for the accept / run / hand-off sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (lastChunk) state_d = DONE;
      DONE:    if (Out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Operand capture on accept, then one chunk of sum and carry per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      opA_q <= '0;
      opB_q <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opA_q <= PW'(A);
            opB_q <= PW'(bIn);
            c_q   <= C_in ^ Sub;
            idx_q <= '0;
          end
        end
        RUN: begin
          res_q[idx_q*CHUNK +: CHUNK] <= chunkSum;
          c_q   <= chunkCarry;
          idx_q <= lastChunk ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign In_ready  = (state_q == IDLE);
  assign Out_valid = (state_q == DONE);
  assign S         = res_q[WIDTH-1:0];
  assign V         = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) && (res_q[WIDTH-1] != opA_q[WIDTH-1]);

  // With padding, the carry out of the real top bit lands in result bit WIDTH;
  // without padding it is the final chunk carry.
  generate
    if (PW > WIDTH) begin : g_padded
      assign C_out = res_q[WIDTH];
    end else begin : g_exact
      assign C_out = c_q;
    end
  endgenerate

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder: a 16/4 instance and a 7/3 instance
// share operand inputs and are compared against an arithmetic reference model.
module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A, B;
  logic        C_in, Sub, Out_ready;
  logic        inValid16, inValid7;

  logic        inReady16, cOut16, v16, outValid16;
  logic [15:0] s16;
  logic        inReady7, cOut7, v7, outValid7;
  logic [6:0]  s7;

  int checkCount = 0;
  int errorCount = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .A(A), .B(B), .C_in(C_in), .Sub(Sub),
    .In_valid(inValid16), .In_ready(inReady16), .S(s16), .C_out(cOut16),
    .V(v16), .Out_valid(outValid16), .Out_ready(Out_ready)
  );

  multicycle_adder #(.WIDTH(7), .CHUNK(3)) dut7 (
    .clk(clk), .rst(rst), .A(A[6:0]), .B(B[6:0]), .C_in(C_in), .Sub(Sub),
    .In_valid(inValid7), .In_ready(inReady7), .S(s7), .C_out(cOut7),
    .V(v7), .Out_valid(outValid7), .Out_ready(Out_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] obsS(input int w);
    return (w == 7) ? {25'b0, s7} : {16'b0, s16};
  endfunction
  function automatic logic obsCout(input int w);
    return (w == 7) ? cOut7 : cOut16;
  endfunction
  function automatic logic obsV(input int w);
    return (w == 7) ? v7 : v16;
  endfunction
  function automatic logic obsOutValid(input int w);
    return (w == 7) ? outValid7 : outValid16;
  endfunction
  function automatic logic obsInReady(input int w);
    return (w == 7) ? inReady7 : inReady16;
  endfunction

  // Arithmetic reference: unsigned result and carry/no-borrow, signed range overflow.
  task automatic refModel(input int w, input longint a, input longint b, input bit cin, input bit sub,
                          output logic [31:0] s, output bit cout, output bit v);
    longint m, half, sa, sb, raw, sr;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    if (!sub) begin
      raw  = a + b + cin;
      cout = (raw >= m);
      sr   = sa + sb + cin;
    end else begin
      raw  = a - b - cin;
      cout = (raw >= 0);
      sr   = sa - sb - cin;
    end
    s = 32'(((raw % m) + m) % m);
    v = (sr >= half) || (sr < -half);
  endtask

  // One full transaction: accept, latency, result, optional backpressure, hand-off.
  task automatic applyStimulus(input int w, input logic [15:0] a, input logic [15:0] b,
                               input bit cin, input bit sub, input int holdCycles,
                               input bit earlyReady, input bit pokeInputs);
    logic [31:0] expS;
    bit          expC, expV;
    int          n, nchunk;
    longint      mask;
    nchunk = (w == 7) ? 3 : 4;
    mask   = (longint'(1) << w) - 1;
    refModel(w, longint'(a) & mask, longint'(b) & mask, cin, sub, expS, expC, expV);

    A = a; B = b; C_in = cin; Sub = sub; Out_ready = earlyReady;
    if (w == 7) inValid7 = 1'b1; else inValid16 = 1'b1;
    n = 0;
    while (!obsInReady(w) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("in_ready_before_accept", {31'b0, obsInReady(w)}, 32'd1);
    @(posedge clk); #1;
    inValid7 = 1'b0; inValid16 = 1'b0;
    A = 16'($urandom); B = 16'($urandom); C_in = 1'($urandom); Sub = 1'($urandom);
    checkOutput("in_ready_busy", {31'b0, obsInReady(w)}, 32'd0);

    n = 0;
    while (!obsOutValid(w) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("latency", 32'(n), 32'(nchunk));
    checkOutput("sum", obsS(w), expS);
    checkOutput("c_out", {31'b0, obsCout(w)}, {31'b0, expC});
    checkOutput("overflow", {31'b0, obsV(w)}, {31'b0, expV});

    if (!earlyReady) begin
      for (int i = 0; i < holdCycles; i++) begin
        if (pokeInputs) begin
          A = 16'($urandom); B = 16'($urandom);
          if (w == 7) inValid7 = 1'b1; else inValid16 = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("hold_valid", {31'b0, obsOutValid(w)}, 32'd1);
        checkOutput("hold_in_ready", {31'b0, obsInReady(w)}, 32'd0);
        checkOutput("hold_sum", obsS(w), expS);
        checkOutput("hold_c_out", {31'b0, obsCout(w)}, {31'b0, expC});
        checkOutput("hold_overflow", {31'b0, obsV(w)}, {31'b0, expV});
      end
      Out_ready = 1'b1;
    end
    @(posedge clk); #1;
    inValid7 = 1'b0; inValid16 = 1'b0; Out_ready = 1'b0;
    checkOutput("release_out_valid", {31'b0, obsOutValid(w)}, 32'd0);
    checkOutput("release_in_ready", {31'b0, obsInReady(w)}, 32'd1);
  endtask

  // Directed cases, mid-run reset, then randomized traffic on both instances.
  initial begin
    rst = 1'b1; A = '0; B = '0; C_in = 1'b0; Sub = 1'b0; Out_ready = 1'b0;
    inValid16 = 1'b0; inValid7 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("reset_out_valid", {31'b0, outValid16}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, inReady16}, 32'd1);
    checkOutput("reset_sum", {16'b0, s16}, 32'd0);
    checkOutput("reset_c_out", {31'b0, cOut16}, 32'd0);
    checkOutput("reset_overflow", {31'b0, v16}, 32'd0);
    checkOutput("reset7_sum", {25'b0, s7}, 32'd0);
    checkOutput("reset7_in_ready", {31'b0, inReady7}, 32'd1);

    applyStimulus(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(16, 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(16, 16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(16, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(16, 16'h0010, 16'h0003, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(7, 16'h007F, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(7, 16'h003F, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(16, 16'hABCD, 16'h1357, 1'b1, 1'b0, 5, 1'b0, 1'b1);
    applyStimulus(16, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    A = 16'h1111; B = 16'h2222; C_in = 1'b0; Sub = 1'b0; inValid16 = 1'b1;
    @(posedge clk); #1;
    inValid16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrun_reset_out_valid", {31'b0, outValid16}, 32'd0);
    checkOutput("midrun_reset_in_ready", {31'b0, inReady16}, 32'd1);
    checkOutput("midrun_reset_sum", {16'b0, s16}, 32'd0);
    applyStimulus(16, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++)
      applyStimulus(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 15; i++)
      applyStimulus(7, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
